// File: rtl/bist_march_ctl.sv
// bist_march_ctl: March C- BIST sequencer for one single-port synchronous RAM with
// configurable read latency, solid/checkerboard background and fail diagnostics.
module bist_march_ctl #(
  parameter int   RWIDTH   = 34,
  parameter int   RDEPTH   = 14,
  parameter int   RLAT     = 1,
  parameter logic W_ENABLE = 1'b0,
  parameter int   FCNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BistMode,
  input  logic              BgSel,
  input  logic [RWIDTH-1:0] D,
  output logic              WEN,
  output logic [RDEPTH-1:0] A,
  output logic [RWIDTH-1:0] Q,
  output logic              BistFail,
  output logic              BistFinish,
  output logic [RDEPTH-1:0] FailAddr,
  output logic [2:0]        FailElem,
  output logic [RWIDTH-1:0] FailBits,
  output logic [FCNT_W-1:0] FailCount
);
  localparam logic W_DISABLE = ~W_ENABLE;
  localparam logic [RDEPTH-1:0] LAST = '1;
  localparam logic [RWIDTH-1:0] CHK = RWIDTH'({RWIDTH{2'b01}});
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;
  state_t st;
  logic [RDEPTH-1:0] addr;
  logic phase, bg_mode;
  logic [2:0] dcnt;
  logic              pv [RLAT];
  logic [RWIDTH-1:0] pe [RLAT];
  logic [RDEPTH-1:0] pa [RLAT];
  logic [2:0]        pl [RLAT];
  logic run, down, last_op, at_end, mis;
  logic [2:0] elem;
  logic [RWIDTH-1:0] pat, diff;
  always_comb begin
    run     = st inside {M0, M1, M2, M3, M4, M5} && BistMode;
    down    = st inside {M3, M4, M5};
    elem    = 3'(st - M0);
    last_op = phase | (st == M5);
    at_end  = addr == (down ? '0 : LAST);
    pat     = (bg_mode ? CHK ^ {RWIDTH{addr[0]}} : '0)
            ^ {RWIDTH{phase ? st inside {M1, M3} : st inside {M2, M4}}};
    diff    = D ^ pe[RLAT-1];
    mis     = pv[RLAT-1] && diff != '0;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st <= IDLE;
      addr <= '0;
      phase <= 1'b0;
      bg_mode <= 1'b0;
      dcnt <= '0;
      WEN <= W_DISABLE;
      A <= '0;
      Q <= '0;
      BistFail <= 1'b0;
      BistFinish <= 1'b0;
      FailAddr <= '0;
      FailElem <= '0;
      FailBits <= '0;
      FailCount <= '0;
      for (int i = 0; i < RLAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= '0;
        pa[i] <= '0;
        pl[i] <= '0;
      end
    end else begin
      for (int i = RLAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pa[i] <= pa[i-1];
        pl[i] <= pl[i-1];
      end
      pv[0] <= run && !phase;
      pe[0] <= pat;
      pa[0] <= addr;
      pl[0] <= elem;
      if (mis) begin
        BistFail <= 1'b1;
        FailBits <= FailBits | diff;
        FailCount <= FailCount == '1 ? FailCount : FailCount + 1'b1;
        if (!BistFail) begin
          FailAddr <= pa[RLAT-1];
          FailElem <= pl[RLAT-1];
        end
      end
      WEN <= W_DISABLE;
      Q <= '0;
      if (st == IDLE && BistMode) begin
        st <= M0;
        bg_mode <= BgSel;
        addr <= '0;
        phase <= 1'b1;
      end
      if (run) begin
        A <= addr;
        WEN <= phase ? W_ENABLE : W_DISABLE;
        Q <= phase ? pat : '0;
        if (!last_op) phase <= 1'b1;
        else if (at_end) begin
          st <= state_t'(st + 4'd1);
          addr <= st inside {M2, M3, M4} ? LAST : '0;
          phase <= 1'b0;
          dcnt <= '0;
        end else begin
          addr <= down ? addr - 1'b1 : addr + 1'b1;
          phase <= st == M0;
        end
      end
      if (st == DRAIN) begin
        dcnt <= dcnt + 1'b1;
        if (dcnt == 3'(RLAT - 1)) begin
          st <= DONE;
          BistFinish <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bist_march_ctl.sv
// tb_bist_march_ctl: runs RLAT=1 and RLAT=3 controllers side by side on behavioural RAMs
// with injected stuck-at faults, checking against an abstract March C- model.
module tb_bist_march_ctl;
  localparam int W = 8, AW = 4;
  logic clk = 0, rst_n = 0, mode = 0, bg = 0;
  logic wen1, wen3, bf1, bf3, fin1, fin3;
  logic [AW-1:0] a1, a3, fad1, fad3;
  logic [W-1:0] q1, q3, rd1, rd3, fbt1, fbt3, fct1, fct3;
  logic [2:0] fel1, fel3;
  logic fe1 = 0, fv1 = 0, fe3 = 0, fv3 = 0;
  logic [3:0] fa1 = 0, fa3 = 0;
  logic [2:0] fb1 = 0, fb3 = 0;
  logic [W-1:0] mem1 [16], mem3 [16], sr3 [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  bist_march_ctl #(.RWIDTH(W), .RDEPTH(AW), .RLAT(1), .W_ENABLE(1'b0), .FCNT_W(8)) u1 (
    .CLK(clk), .RST(rst_n), .BistMode(mode), .BgSel(bg), .D(rd1), .WEN(wen1), .A(a1), .Q(q1),
    .BistFail(bf1), .BistFinish(fin1), .FailAddr(fad1), .FailElem(fel1), .FailBits(fbt1), .FailCount(fct1));
  bist_march_ctl #(.RWIDTH(W), .RDEPTH(AW), .RLAT(3), .W_ENABLE(1'b0), .FCNT_W(8)) u3 (
    .CLK(clk), .RST(rst_n), .BistMode(mode), .BgSel(bg), .D(rd3), .WEN(wen3), .A(a3), .Q(q3),
    .BistFail(bf3), .BistFinish(fin3), .FailAddr(fad3), .FailElem(fel3), .FailBits(fbt3), .FailCount(fct3));
  function automatic logic [W-1:0] flt(logic [W-1:0] v, logic [3:0] a, logic e, logic [3:0] fa,
                                       logic [2:0] fb, logic fv);
    logic [W-1:0] m;
    m = 8'h01 << fb;
    return (e && a == fa) ? (fv ? v | m : v & ~m) : v;
  endfunction
  assign rd1 = flt(mem1[a1], a1, fe1, fa1, fb1, fv1);
  assign rd3 = sr3[1];
  always @(posedge clk) begin
    if (!wen1) mem1[a1] <= q1;
    if (!wen3) mem3[a3] <= q3;
    sr3[0] <= flt(mem3[a3], a3, fe3, fa3, fb3, fv3);
    sr3[1] <= sr3[0];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic bgv, input logic fe, input logic [3:0] fa, input logic [2:0] fb,
                       input logic fv, output logic ef, output logic [3:0] ea, output logic [2:0] el,
                       output logic [7:0] eb, output logic [7:0] ec);
    logic [7:0] m [16];
    logic [7:0] b, o, x;
    int a;
    ef = 0; ea = 0; el = 0; eb = 0; ec = 0;
    for (int e = 0; e < 6; e++)
      for (int j = 0; j < 16; j++) begin
        a = e >= 3 ? 15 - j : j;
        b = bgv ? ((a % 2 == 1) ? 8'hAA : 8'h55) : 8'h00;
        if (e != 0) begin
          o = m[a];
          if (fe && a == int'(fa)) o = fv ? o | (8'h01 << fb) : o & ~(8'h01 << fb);
          x = b ^ ((e == 2 || e == 4) ? 8'hFF : 8'h00);
          if (o != x) begin
            if (!ef) begin ea = 4'(a); el = 3'(e); end
            ef = 1;
            eb |= o ^ x;
            ec++;
          end
        end
        if (e != 5) m[a] = b ^ ((e == 1 || e == 3) ? 8'hFF : 8'h00);
      end
  endtask
  task automatic chk_reset(input string tag);
    check({tag, "_1"}, {wen1, a1, q1, bf1, fin1, fad1, fel1, fbt1, fct1}, {1'b1, 37'b0});
    check({tag, "_3"}, {wen3, a3, q3, bf3, fin3, fad3, fel3, fbt3, fct3}, {1'b1, 37'b0});
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    mode = 0;
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic run(input logic bgv, input int p, input int l, input logic chkq);
    int k, e1, e3;
    logic ef;
    logic [3:0] ea;
    logic [2:0] el;
    logic [7:0] eb, ec;
    bg = bgv;
    mode = 1;
    k = 0; e1 = 0; e3 = 0;
    while ((e1 == 0 || e3 == 0) && k < 400) begin
      @(negedge clk);
      k++;
      if (fin1 && e1 == 0) e1 = k;
      if (fin3 && e3 == 0) e3 = k;
      if (l > 0 && k > p && k <= p + l) begin
        check("pause_wen1", wen1, 1);
        check("pause_wen3", wen3, 1);
      end
      if (chkq && (k == 4 || k == 5)) begin
        check("m0_a1", a1, k - 2);
        check("m0_q1", q1, k == 4 ? 8'h55 : 8'hAA);
        check("m0_q3", q3, k == 4 ? 8'h55 : 8'hAA);
      end
      if (l > 0 && k == p) mode = 0;
      if (l > 0 && k == p + l) mode = 1;
    end
    check("fin1_edge", e1, 162 + l);
    check("fin3_edge", e3, 164 + l);
    repeat (4) begin
      @(negedge clk);
      mode = ~mode;
    end
    @(negedge clk);
    check("done_hold1", {fin1, wen1}, 2'b11);
    check("done_hold3", {fin3, wen3}, 2'b11);
    model(bgv, fe1, fa1, fb1, fv1, ef, ea, el, eb, ec);
    check("res1", {bf1, fad1, fel1, fbt1, fct1}, {ef, ea, el, eb, ec});
    model(bgv, fe3, fa3, fb3, fv3, ef, ea, el, eb, ec);
    check("res3", {bf3, fad3, fel3, fbt3, fct3}, {ef, ea, el, eb, ec});
    mode = 0;
  endtask
  initial begin
    do_reset();
    run(0, 0, 0, 0);
    do_reset();
    fe1 = 1; fa1 = 5; fb1 = 3; fv1 = 1;
    fe3 = 1; fa3 = 15; fb3 = 0; fv3 = 0;
    run(0, 0, 0, 0);
    check("plan_sa1", {bf1, fad1, fel1, fbt1, fct1}, {1'b1, 4'd5, 3'd1, 8'h08, 8'd3});
    check("plan_sa0", {bf3, fad3, fel3, fct3}, {1'b1, 4'd15, 3'd2, 8'd2});
    do_reset();
    run(0, 90, 7, 0);
    do_reset();
    fe1 = 0; fe3 = 0;
    run(1, 0, 0, 1);
    do_reset();
    mode = 1;
    repeat (60) @(negedge clk);
    #1 rst_n = 0;
    #1 chk_reset("midrun_rst");
    mode = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 0, 0, 0);
    for (int n = 0; n < 6; n++) begin
      do_reset();
      fe1 = 1'($urandom); fa1 = 4'($urandom); fb1 = 3'($urandom); fv1 = 1'($urandom);
      fe3 = 1'($urandom); fa3 = 4'($urandom); fb3 = 3'($urandom); fv3 = 1'($urandom);
      run(1'($urandom), $urandom_range(140, 1), $urandom_range(10, 0), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
